clk_div3_counter: RTL and testbench
===================================

# clk_div3_counter

Divide-by-3 clock generator built from a two-flip-flop synchronous counter with a terminal-count clear. It takes the system clock and produces `q_out` at one third of the input frequency. The block sits at the clock-generation boundary and feeds slower logic or an observation pin. Its internal counter bits and the clear decode are kept visible for waveform debug.

## Interface
- Parameters: none. The divide ratio is fixed at 3.
- `clk_in`  input  1  input clock; all state changes on the rising edge, plus the falling edge when 50 % duty is compiled in
- `rst`  input  1  asynchronous, active-high reset
- `q_out`  output  1  divided clock, frequency clk_in/3
- Required internal nets, reachable hierarchically by the bench:
  - `q1_out`: counter bit 0 (FF1 Q)
  - `q2_out`: counter bit 1 (FF2 Q)
  - `clear_signal`: terminal-count clear

## Operation
- Counter state is {`q2_out`,`q1_out`}.
- Legal sequence: 00 → 01 → 10 → 00, repeating. Period is 3 `clk_in` cycles.
- `clear_signal` = `q2_out`. It is combinational and high in state 10.
- When `clear_signal` is high, the next rising edge loads 00.
- Otherwise the counter increments by 1 on each rising edge.
- Illegal state 11: `clear_signal` is high, so the next rising edge goes to 00. Recovery takes at most 1 cycle.
- Default output: `q_out` = `q2_out`, registered with no combinational glitch path. It is high 1 of every 3 cycles (33 % duty).
- Reset (`rst`=1), asynchronous, takes effect immediately regardless of clock:
  - `q1_out`=0, `q2_out`=0, `q_out`=0
  - any falling-edge flop = 0
  - reset held: outputs stay 0 and no counting occurs

## Timing
- First rising edge after `rst` deasserts: state 01, `q_out`=0.
- 2nd edge: state 10. `q_out` rises (default mode), `clear_signal`=1.
- 3rd edge: state 00, `q_out`=0. The sequence then repeats with a period of 3 edges.
- `q_out` changes only on `clk_in` edges. Latency from the clock edge to output equals one flop clock-to-Q.
- Reset asserted mid-sequence: all outputs go to 0 without waiting for a clock edge. Counting restarts from 00 at the first rising edge after release.
- Reset released coincident with a rising edge: that edge may or may not count. The sequence is still legal afterwards.

## Configuration
- Macro: `CLK_DIV3_DUTY50_EN`.
- Undefined (default) behaviour:
  - `q_out` = `q2_out`
  - 33 % duty
  - rising edge only
- Defined behaviour:
  - Add flop `q1_neg`, which samples `q1_out` on the falling edge of `clk_in` and is asynchronously reset to 0.
  - `q_out` = `q1_out` | `q1_neg`.
  - `q_out` rises on the rising edge that enters state 01 and falls on the falling edge 1.5 cycles later. This gives 50 % duty with period 3 cycles.
- Counter, `clear_signal` and reset behaviour are identical in both builds.

## Test plan
- **Reset hold.** Clock at 20 ns period, `rst`=1 for 30 ns → `q_out`, `q1_out`, `q2_out` all 0 throughout.
- **Count sequence.** Release `rst` and run 200 ns → {`q2_out`,`q1_out`} reads 01, 10, 00, 01, … on consecutive rising edges. `clear_signal`=1 only in state 10.
- **Output frequency (default build).** Run as above → `q_out` high for 20 ns and low for 40 ns, with a 60 ns period.
- **Mid-run reset.** Assert `rst` for 5 ns between edges while in state 10 → all outputs 0 immediately. The first edge after release gives state 01.
- **Illegal state.** Force state 11 → `clear_signal`=1, and the next rising edge gives 00.
- **Duty-cycle build.** Define `CLK_DIV3_DUTY50_EN` and run 200 ns → `q_out` high for 30 ns and low for 30 ns, with a 60 ns period.

Source files
------------

// File: rtl/clk_div3_counter.sv
// rtl/clk_div3_counter.sv - divide-by-3 clock from a 2-bit terminal-clear counter
// Optional 50 % duty output: define CLK_DIV3_DUTY50_EN.
module clk_div3_counter (
  input  logic clk_in,
  input  logic rst,
  output logic q_out
);

  logic q1_q, q1_d;
  logic q2_q, q2_d;
  logic q1_out;
  logic q2_out;
  logic clear_signal;

  assign q1_out       = q1_q;
  assign q2_out       = q2_q;
  assign clear_signal = q2_out;

  // Any state with bit 1 set (10 or illegal 11) clears to 00.
  // Otherwise bit 1 is 0, so +1 reduces to the shift below.
  always_comb begin
    q1_d = 1'b0;
    q2_d = 1'b0;
    if (!clear_signal) begin
      q1_d = ~q1_out;
      q2_d = q1_out;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      q1_q <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

`ifdef CLK_DIV3_DUTY50_EN
  logic q1_neg;

  // Half-cycle-delayed copy of bit 0 stretches the high time to 1.5 cycles.
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      q1_neg <= 1'b0;
    end else begin
      q1_neg <= q1_out;
    end
  end

  assign q_out = q1_out | q1_neg;
`else
  assign q_out = q2_out;
`endif

endmodule

// File: tb/tb_clk_div3_counter.sv
// tb/tb_clk_div3_counter.sv - randomized self-checking bench for clk_div3_counter
module tb_clk_div3_counter;

  logic clk_in;
  logic rst;
  logic q_out;

  int errors;
  int checks;
  int k;

  clk_div3_counter dut (
    .clk_in (clk_in),
    .rst    (rst),
    .q_out  (q_out)
  );

  initial clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  function automatic logic [1:0] exp_state(input int n);
    return 2'(n % 3);
  endfunction

  // second_half: sample taken after the falling edge within the cycle.
  function automatic logic exp_q(input int n, input bit second_half);
    int ph;
    ph = n % 3;
`ifdef CLK_DIV3_DUTY50_EN
    if (second_half) return (ph == 1);
    return (ph == 1) || (ph == 2);
`else
    return (ph == 2);
`endif
  endfunction

  task automatic step();
    logic [1:0] st;
    @(posedge clk_in);
    k++;
    #5;
    st = {dut.q2_out, dut.q1_out};
    checks++;
    if (st !== exp_state(k)) begin
      errors++;
      $display("FAIL state k=%0d got=%b exp=%b", k, st, exp_state(k));
    end
    checks++;
    if (dut.clear_signal !== (exp_state(k) == 2'b10)) begin
      errors++;
      $display("FAIL clear k=%0d got=%b exp=%b", k, dut.clear_signal, exp_state(k) == 2'b10);
    end
    checks++;
    if (q_out !== exp_q(k, 1'b0)) begin
      errors++;
      $display("FAIL q_out_hi_half k=%0d got=%b exp=%b", k, q_out, exp_q(k, 1'b0));
    end
    @(negedge clk_in);
    #5;
    checks++;
    if (q_out !== exp_q(k, 1'b1)) begin
      errors++;
      $display("FAIL q_out_lo_half k=%0d got=%b exp=%b", k, q_out, exp_q(k, 1'b1));
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({q_out, dut.q2_out, dut.q1_out, dut.clear_signal} !== 4'b0000) begin
      errors++;
      $display("FAIL %s q_out=%b q2=%b q1=%b clear=%b exp=0000", tag, q_out,
               dut.q2_out, dut.q1_out, dut.clear_signal);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #5;
      check_zero("reset_hold");
    end
    @(negedge clk_in);
    rst = 1'b0;
    k = 0;
  endtask

  task automatic test_count();
    int n;
    n = 10 + int'($urandom_range(0, 5));
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_frequency();
    int highs;
    int rises;
    logic prev;
    highs = 0;
    rises = 0;
    while (k % 3 != 0) step();
    prev = q_out;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk_in);
      k++;
      #5;
      if (q_out) highs++;
      if (q_out && !prev) rises++;
      prev = q_out;
      @(negedge clk_in);
      #5;
      if (q_out) highs++;
      if (q_out && !prev) rises++;
      prev = q_out;
    end
    checks++;
`ifdef CLK_DIV3_DUTY50_EN
    if (highs !== 18) begin
`else
    if (highs !== 12) begin
`endif
      errors++;
      $display("FAIL duty high_half_cycles=%0d of 36", highs);
    end
    checks++;
    if (rises !== 6) begin
      errors++;
      $display("FAIL period rises=%0d exp=6", rises);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk_in);
    #($urandom_range(1, 4));
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    #4;
    rst = 1'b0;
    k = 0;
    step();
  endtask

  task automatic test_mid_reset();
    while (k % 3 != 2) step();
    mid_reset();
  endtask

  task automatic test_illegal();
    @(negedge clk_in);
    force dut.q1_out = 1'b1;
    force dut.q2_out = 1'b1;
    #1;
    checks++;
    if (dut.clear_signal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_clear got=%b exp=1", dut.clear_signal);
    end
    @(posedge clk_in);
    #1;
    release dut.q1_out;
    release dut.q2_out;
    #1;
    checks++;
    if ({dut.q2_out, dut.q1_out} !== 2'b00) begin
      errors++;
      $display("FAIL illegal_recover got=%b exp=00", {dut.q2_out, dut.q1_out});
    end
    @(negedge clk_in);
    k = 3;
    step();
    step();
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mid_reset();
      end else begin
        for (int j = 0; j < int'($urandom_range(1, 7)); j++) step();
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    k = 0;
    rst = 1'b1;
    test_reset();
    test_count();
    test_frequency();
    test_mid_reset();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
